// File: rtl/hdma_engine_v2_if.sv
// Bus bundle between the HDMA register decode / memory muxes and the VRAM DMA engine.
// The slave modport is the engine's view; master is the surrounding system.
interface hdma_engine_v2_if #(
    parameter int SRC_W = 16,
    parameter int DST_W = 13,
    parameter int LEN_W = 7
);
    logic             start;
    logic             start_mode;
    logic [LEN_W-1:0] start_len;
    logic [SRC_W-1:0] src_addr;
    logic [DST_W-1:0] dst_addr;
    logic             hblank;
    logic             lcd_on;
    logic             rd_en;
    logic [SRC_W-1:0] rd_addr;
    logic [7:0]       rd_data;
    logic             wr_en;
    logic [DST_W-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic             cpu_stall;
    logic             active;
    logic [7:0]       hdma5_rd;
    logic             done;

    modport master (
        output start, start_mode, start_len, src_addr, dst_addr, hblank, lcd_on, rd_data,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, cpu_stall, active, hdma5_rd, done
    );

    modport slave (
        input  start, start_mode, start_len, src_addr, dst_addr, hblank, lcd_on, rd_data,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, cpu_stall, active, hdma5_rd, done
    );
endinterface

// File: rtl/hdma_engine_v2.sv
// CGB VRAM DMA engine supporting general-purpose (back-to-back) and HBlank (one block per HBlank) transfers.
// Each block reads 2^BLK_LOG2 source bytes and writes them to VRAM one cycle later, stalling the CPU meanwhile.
module hdma_engine_v2 #(
    parameter int SRC_W    = 16,
    parameter int DST_W    = 13,
    parameter int LEN_W    = 7,
    parameter int BLK_LOG2 = 4
) (
    input logic              clk4_2,
    input logic              reset_n,
    hdma_engine_v2_if.slave  bus
);
    localparam int OFF_W = LEN_W + 1 + BLK_LOG2;
    localparam logic [SRC_W-1:0] SRC_MASK = ~SRC_W'((1 << BLK_LOG2) - 1);
    localparam logic [DST_W-1:0] DST_MASK = ~DST_W'((1 << BLK_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, WAIT_HBL, COPY, LAST_WR} state_t;

    state_t              state, state_nx;
    logic [BLK_LOG2-1:0] idx, idx_nx;
    logic [LEN_W:0]      blk, blk_nx;
    logic [LEN_W-1:0]    len, len_nx;
    logic [SRC_W-1:0]    src_base, src_nx;
    logic [DST_W-1:0]    dst_base, dst_nx;
    logic                hdma_mode, mode_nx;
    logic                hblank_pend, pend_nx;
    logic                cancel_pend, cancel_nx;
    logic                restart_pend, restart_nx;
    logic [LEN_W-1:0]    rs_len, rs_len_nx;
    logic [SRC_W-1:0]    rs_src, rs_src_nx;
    logic [DST_W-1:0]    rs_dst, rs_dst_nx;
    logic [OFF_W-1:0]    rd_off, rd_off_nx;

    logic                rd_en_q, rd_en_nx;
    logic [SRC_W-1:0]    rd_addr_q, rd_addr_nx;
    logic                wr_en_q, wr_en_nx;
    logic [DST_W-1:0]    wr_addr_q, wr_addr_nx;
    logic                stall_q, stall_nx;
    logic                active_q, active_nx;
    logic                done_q, done_nx;
    logic [7:0]          hdma5_q, hdma5_nx;

    logic                load_new;
    logic                load_from_bus;
    logic                hdma_req;
    logic                cancel_req;
    logic                last_blk;
    logic [SRC_W-1:0]    src_aligned;
    logic [DST_W-1:0]    dst_aligned;
    logic [LEN_W:0]      rem_m1;

    assign hdma_req    = bus.start && bus.start_mode;
    assign cancel_req  = bus.start && !bus.start_mode;
    assign last_blk    = (blk == {1'b0, len});
    assign src_aligned = bus.src_addr & SRC_MASK;
    assign dst_aligned = bus.dst_addr & DST_MASK;

    // Sequencing: starts, cancels and restarts are only honoured at block boundaries,
    // so a block that has begun always finishes its final write.
    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        blk_nx        = blk;
        len_nx        = len;
        src_nx        = src_base;
        dst_nx        = dst_base;
        mode_nx       = hdma_mode;
        pend_nx       = hblank_pend;
        cancel_nx     = cancel_pend;
        restart_nx    = restart_pend;
        rs_len_nx     = rs_len;
        rs_src_nx     = rs_src;
        rs_dst_nx     = rs_dst;
        done_nx       = 1'b0;
        load_new      = 1'b0;
        load_from_bus = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load_new      = 1'b1;
                    load_from_bus = 1'b1;
                    state_nx      = (bus.start_mode && bus.lcd_on) ? WAIT_HBL : COPY;
                end
            end
            WAIT_HBL: begin
                if (cancel_req) begin
                    state_nx = IDLE;
                end else if (hdma_req) begin
                    load_new      = 1'b1;
                    load_from_bus = 1'b1;
                    state_nx      = bus.lcd_on ? WAIT_HBL : COPY;
                end else if (bus.hblank || hblank_pend || !bus.lcd_on) begin
                    state_nx = COPY;
                end
            end
            COPY, LAST_WR: begin
                if (bus.hblank) begin
                    pend_nx = 1'b1;
                end
                if (hdma_mode && hdma_req) begin
                    restart_nx = 1'b1;
                    cancel_nx  = 1'b0;
                    rs_len_nx  = bus.start_len;
                    rs_src_nx  = src_aligned;
                    rs_dst_nx  = dst_aligned;
                end else if (hdma_mode && cancel_req) begin
                    cancel_nx  = 1'b1;
                    restart_nx = 1'b0;
                end

                if (state == COPY) begin
                    idx_nx = idx + BLK_LOG2'(1);
                    if (idx == '1) begin
                        state_nx = LAST_WR;
                    end
                end else begin
                    blk_nx = blk + (LEN_W + 1)'(1);
                    if (restart_nx) begin
                        load_new = 1'b1;
                        state_nx = bus.lcd_on ? WAIT_HBL : COPY;
                    end else if (cancel_nx) begin
                        cancel_nx = 1'b0;
                        state_nx  = IDLE;
                    end else if (last_blk) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else if (!hdma_mode || pend_nx || !bus.lcd_on) begin
                        state_nx = COPY;
                    end else begin
                        state_nx = WAIT_HBL;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (load_new) begin
            src_nx     = load_from_bus ? src_aligned    : rs_src_nx;
            dst_nx     = load_from_bus ? dst_aligned    : rs_dst_nx;
            len_nx     = load_from_bus ? bus.start_len  : rs_len_nx;
            mode_nx    = load_from_bus ? bus.start_mode : 1'b1;
            blk_nx     = '0;
            idx_nx     = '0;
            pend_nx    = 1'b0;
            cancel_nx  = 1'b0;
            restart_nx = 1'b0;
        end

        if (state_nx == COPY && state != COPY) begin
            pend_nx = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they can be registered with it.
    // Writes replay the previous cycle's read offset, matching the 1-cycle read latency.
    always_comb begin
        rd_off_nx  = {blk_nx, idx_nx};
        rd_en_nx   = (state_nx == COPY);
        rd_addr_nx = rd_en_nx ? src_nx + SRC_W'(rd_off_nx) : '0;
        wr_en_nx   = rd_en_q;
        wr_addr_nx = rd_en_q ? dst_base + DST_W'(rd_off) : '0;
        stall_nx   = (state_nx == COPY) || (state_nx == LAST_WR);
        active_nx  = (state_nx != IDLE);
        rem_m1     = {1'b0, len_nx} - blk_nx;

        if (state_nx == IDLE && state == IDLE) begin
            hdma5_nx = hdma5_q;
        end else if (done_nx) begin
            hdma5_nx = 8'hFF;
        end else begin
            hdma5_nx = {~active_nx, 7'(rem_m1)};
        end
    end

    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            blk          <= '0;
            len          <= '0;
            src_base     <= '0;
            dst_base     <= '0;
            hdma_mode    <= 1'b0;
            hblank_pend  <= 1'b0;
            cancel_pend  <= 1'b0;
            restart_pend <= 1'b0;
            rs_len       <= '0;
            rs_src       <= '0;
            rs_dst       <= '0;
            rd_off       <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            stall_q      <= 1'b0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            hdma5_q      <= 8'hFF;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            blk          <= blk_nx;
            len          <= len_nx;
            src_base     <= src_nx;
            dst_base     <= dst_nx;
            hdma_mode    <= mode_nx;
            hblank_pend  <= pend_nx;
            cancel_pend  <= cancel_nx;
            restart_pend <= restart_nx;
            rs_len       <= rs_len_nx;
            rs_src       <= rs_src_nx;
            rs_dst       <= rs_dst_nx;
            rd_off       <= rd_off_nx;
            rd_en_q      <= rd_en_nx;
            rd_addr_q    <= rd_addr_nx;
            wr_en_q      <= wr_en_nx;
            wr_addr_q    <= wr_addr_nx;
            stall_q      <= stall_nx;
            active_q     <= active_nx;
            done_q       <= done_nx;
            hdma5_q      <= hdma5_nx;
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = bus.rd_data;
    assign bus.cpu_stall = stall_q;
    assign bus.active    = active_q;
    assign bus.done      = done_q;
    assign bus.hdma5_rd  = hdma5_q;
endmodule

// File: tb/tb_hdma_engine_v2.sv
// Directed bench for hdma_engine_v2: a table of complete transfers plus hand-written HDMA corner sequences.
// A source-memory model feeds rd_data and a monitor tracks expected addresses, data and stall bursts.
module tb_hdma_engine_v2;
    logic clk4_2;
    logic reset_n;

    hdma_engine_v2_if bus ();

    hdma_engine_v2 dut (
        .clk4_2  (clk4_2),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        mode;
        logic        lcd;
        logic [6:0]  len;
        logic [15:0] src;
        logic [12:0] dst;
        int          exp_writes;
        int          exp_run;
    } vec_t;

    vec_t vecs [5];

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mon_src = '0;
    logic [12:0] mon_dst = '0;
    int wn = 0, rn = 0, wr_err = 0, rd_err = 0, done_cnt = 0;
    int bursts = 0, bad_bursts = 0, last_run = 0, run = 0, gap_cnt = 0;

    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    initial clk4_2 = 1'b0;
    always #5 clk4_2 = ~clk4_2;

    // Source memory with one cycle of read latency.
    always @(posedge clk4_2) begin
        bus.rd_data <= bus.rd_en ? src_byte(bus.rd_addr) : 8'h00;
    end

    // A start seen while idle opens a new transfer record in the monitor.
    always @(negedge clk4_2) begin
        if (bus.start && !bus.active) begin
            mon_src    = bus.src_addr & 16'hFFF0;
            mon_dst    = bus.dst_addr & 13'h1FF0;
            wn         = 0;
            rn         = 0;
            wr_err     = 0;
            rd_err     = 0;
            done_cnt   = 0;
            bursts     = 0;
            bad_bursts = 0;
            last_run   = 0;
            run        = 0;
            gap_cnt    = 0;
        end else begin
            if (bus.rd_en) begin
                if (bus.rd_addr !== 16'(mon_src + 16'(rn))) rd_err++;
                rn++;
            end
            if (bus.wr_en) begin
                if (bus.wr_addr !== 13'(mon_dst + 13'(wn)) ||
                    bus.wr_data !== src_byte(16'(mon_src + 16'(wn)))) wr_err++;
                wn++;
            end
            if (bus.done) done_cnt++;
            if (bus.active && !bus.cpu_stall) gap_cnt++;
            if (bus.cpu_stall) begin
                run++;
            end else if (run != 0) begin
                bursts++;
                if (run != 17) bad_bursts++;
                last_run = run;
                run = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic applyStimulus(input logic mode, input logic lcd, input logic [6:0] len,
                                 input logic [15:0] src, input logic [12:0] dst);
        @(posedge clk4_2);
        #1;
        bus.start      = 1'b1;
        bus.start_mode = mode;
        bus.start_len  = len;
        bus.src_addr   = src;
        bus.dst_addr   = dst;
        bus.lcd_on     = lcd;
        @(posedge clk4_2);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic hblankPulse();
        @(posedge clk4_2);
        #1 bus.hblank = 1'b1;
        @(posedge clk4_2);
        #1 bus.hblank = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int timed_out;
        timed_out = 1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk4_2);
            if (!bus.active) begin
                timed_out = 0;
                break;
            end
        end
        checkOutput({name, " timeout"}, timed_out, 0);
        @(negedge clk4_2);
    endtask

    task automatic runVector(input int i);
        applyStimulus(vecs[i].mode, vecs[i].lcd, vecs[i].len, vecs[i].src, vecs[i].dst);
        waitIdle($sformatf("v%0d", i));
        checkOutput($sformatf("v%0d writes", i), wn, vecs[i].exp_writes);
        checkOutput($sformatf("v%0d reads", i), rn, vecs[i].exp_writes);
        checkOutput($sformatf("v%0d wr errors", i), wr_err, 0);
        checkOutput($sformatf("v%0d rd errors", i), rd_err, 0);
        checkOutput($sformatf("v%0d done pulses", i), done_cnt, 1);
        checkOutput($sformatf("v%0d stall run", i), last_run, vecs[i].exp_run);
        checkOutput($sformatf("v%0d stall bursts", i), bursts, 1);
        checkOutput($sformatf("v%0d idle gaps", i), gap_cnt, 0);
        checkOutput($sformatf("v%0d hdma5", i), int'(bus.hdma5_rd), 8'hFF);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.start_mode = 1'b0;
        bus.start_len  = '0;
        bus.src_addr   = '0;
        bus.dst_addr   = '0;
        bus.hblank     = 1'b0;
        bus.lcd_on     = 1'b1;

        vecs[0] = '{1'b0, 1'b1, 7'd0,  16'hC000, 13'h0000, 16,   17};
        vecs[1] = '{1'b0, 1'b1, 7'd3,  16'h1234, 13'h0105, 64,   68};
        vecs[2] = '{1'b0, 1'b1, 7'd1,  16'hFFF0, 13'h1FF0, 32,   34};
        vecs[3] = '{1'b0, 1'b1, 7'h7F, 16'h8000, 13'h1FF0, 2048, 2176};
        vecs[4] = '{1'b1, 1'b0, 7'd2,  16'h4000, 13'h0800, 48,   51};

        repeat (3) @(posedge clk4_2);
        @(negedge clk4_2);
        checkOutput("reset ctl", int'({bus.rd_en, bus.wr_en, bus.cpu_stall, bus.active, bus.done}), 0);
        checkOutput("reset hdma5", int'(bus.hdma5_rd), 8'hFF);
        checkOutput("reset addr", int'(bus.rd_addr) + int'(bus.wr_addr), 0);
        @(posedge clk4_2);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            runVector(i);
        end

        // HDMA, three blocks paced by HBlank every 456 cycles.
        applyStimulus(1'b1, 1'b1, 7'd2, 16'hA000, 13'h0400);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk4_2);
            checkOutput($sformatf("hdma hdma5 before blk%0d", b), int'(bus.hdma5_rd), 2 - b);
            hblankPulse();
            repeat (454) @(posedge clk4_2);
        end
        @(negedge clk4_2);
        checkOutput("hdma hdma5 final", int'(bus.hdma5_rd), 8'hFF);
        checkOutput("hdma active final", int'(bus.active), 0);
        checkOutput("hdma done pulses", done_cnt, 1);
        checkOutput("hdma bursts", bursts, 3);
        checkOutput("hdma bad bursts", bad_bursts, 0);
        checkOutput("hdma writes", wn, 48);
        checkOutput("hdma wr errors", wr_err, 0);

        // HDMA cancelled while waiting for HBlank after two blocks.
        applyStimulus(1'b1, 1'b1, 7'd4, 16'h2000, 13'h0000);
        repeat (2) begin
            hblankPulse();
            repeat (30) @(posedge clk4_2);
        end
        @(negedge clk4_2);
        checkOutput("cancel pre hdma5", int'(bus.hdma5_rd), 8'h02);
        applyStimulus(1'b0, 1'b1, 7'd0, 16'h2000, 13'h0000);
        @(negedge clk4_2);
        checkOutput("cancel active", int'(bus.active), 0);
        checkOutput("cancel hdma5", int'(bus.hdma5_rd), 8'h82);
        repeat (10) @(posedge clk4_2);
        @(negedge clk4_2);
        checkOutput("cancel hdma5 held", int'(bus.hdma5_rd), 8'h82);
        checkOutput("cancel done pulses", done_cnt, 0);
        checkOutput("cancel writes", wn, 32);
        checkOutput("cancel wr errors", wr_err, 0);

        // HBlank arriving mid-block lets the next block follow with no wait.
        applyStimulus(1'b1, 1'b1, 7'd1, 16'h3000, 13'h0200);
        hblankPulse();
        repeat (5) @(posedge clk4_2);
        hblankPulse();
        waitIdle("pend");
        checkOutput("pend bursts", bursts, 1);
        checkOutput("pend stall run", last_run, 34);
        checkOutput("pend done pulses", done_cnt, 1);
        checkOutput("pend writes", wn, 32);
        checkOutput("pend wr errors", wr_err, 0);

        // Asynchronous reset in the middle of a GDMA block, then a fresh transfer.
        applyStimulus(1'b0, 1'b1, 7'd3, 16'hC000, 13'h0000);
        repeat (10) @(posedge clk4_2);
        #1 reset_n = 1'b0;
        #2;
        checkOutput("midreset ctl", int'({bus.rd_en, bus.wr_en, bus.cpu_stall, bus.active, bus.done}), 0);
        checkOutput("midreset hdma5", int'(bus.hdma5_rd), 8'hFF);
        checkOutput("midreset addr", int'(bus.rd_addr) + int'(bus.wr_addr), 0);
        @(posedge clk4_2);
        #1 reset_n = 1'b1;
        runVector(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
